// File: rtl/mem_delayed_if.sv
// Request/response bus between the processor memory port and mem_delayed.
// The err signal exists only when MEM_BOUNDS_CHECK_EN is defined.
interface mem_delayed_if;
  logic [31:0] addr;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ack;
  logic        busy;
`ifdef MEM_BOUNDS_CHECK_EN
  logic        err;

  modport master (
    output addr, rd_req, wr_req, wr_data,
    input  rd_data, ack, busy, err
  );
  modport slave (
    input  addr, rd_req, wr_req, wr_data,
    output rd_data, ack, busy, err
  );
`else
  modport master (
    output addr, rd_req, wr_req, wr_data,
    input  rd_data, ack, busy
  );
  modport slave (
    input  addr, rd_req, wr_req, wr_data,
    output rd_data, ack, busy
  );
`endif
endinterface

// File: rtl/mem_delayed.sv
// Word-addressed memory with fixed LATENCY access time and an out-of-band write port.
// Define MEM_BOUNDS_CHECK_EN to reject out-of-range addresses and flag them on err.
module mem_delayed #(
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 5
) (
  input  logic         clk,
  input  logic         rst,
  mem_delayed_if.slave bus,
  input  logic         oob_wen,
  input  logic [31:0]  oob_wr_addr,
  input  logic [31:0]  oob_wr_data
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept, complete, use_live, core_we;
  logic [AW-1:0]   req_idx, oob_idx, lat_idx, cur_idx;
  logic [31:0]     lat_data, cur_data;
  logic            lat_wr, cur_wr;
  logic            req_oor, oob_oor, lat_oor, cur_oor;
  logic [31:0]     rd_data_q;
  logic            ack_q;
  logic [31:0]     mem [MEM_DEPTH];

  assign req_idx = bus.addr[AW-1:0];
  assign oob_idx = oob_wr_addr[AW-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  logic err_q;
  assign req_oor = (bus.addr >> AW) != '0;
  assign oob_oor = (oob_wr_addr >> AW) != '0;
  assign bus.err = err_q;
`else
  // Without bounds checking the upper address bits simply wrap away.
  logic unused_upper;
  assign req_oor      = 1'b0;
  assign oob_oor      = 1'b0;
  assign unused_upper = ^{bus.addr[31:AW], oob_wr_addr[31:AW]};
`endif

  assign accept   = (state_q == IDLE) && (bus.rd_req || bus.wr_req);
  // With LATENCY=1 the request completes on its own acceptance edge, so it uses live inputs.
  assign use_live = (state_q == IDLE);
  assign cur_idx  = use_live ? req_idx     : lat_idx;
  assign cur_data = use_live ? bus.wr_data : lat_data;
  assign cur_wr   = use_live ? bus.wr_req  : lat_wr;
  assign cur_oor  = use_live ? req_oor     : lat_oor;
  assign core_we  = complete && cur_wr && !cur_oor && !rst;

  assign bus.busy    = (state_q == WAIT);
  assign bus.ack     = ack_q;
  assign bus.rd_data = rd_data_q;

  // NOTE: combinational logic uses blocking '=' and assigns every output a default
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            complete = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      rd_data_q <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= complete;
      rd_data_q <= (complete && !cur_wr && !cur_oor) ? mem[cur_idx] : '0;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q     <= complete && cur_oor;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_idx  <= req_idx;
      lat_data <= bus.wr_data;
      lat_wr   <= bus.wr_req;
      lat_oor  <= req_oor;
    end
  end

  // NOTE: the array has no reset; clearing it would forbid RAM inference and reset
  // must not disturb a program already loaded through the OOB port.
  // The core write is placed last so it wins a same-index collision with OOB.
  always_ff @(posedge clk) begin
    if (oob_wen && !oob_oor) mem[oob_idx] <= oob_wr_data;
    if (core_we)             mem[cur_idx] <= cur_data;
  end
endmodule

// File: tb/tb_mem_delayed.sv
// Self-checking bench for mem_delayed: directed table, multi-cycle corner cases,
// and randomized transactions against an array-based reference model.
module tb_mem_delayed;
  localparam int DEPTH = 1024;
  localparam int LAT   = 5;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        oob_wen;
  logic [31:0] oob_wr_addr, oob_wr_data;

  mem_delayed_if bus ();

  mem_delayed #(.MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .oob_wen    (oob_wen),
    .oob_wr_addr(oob_wr_addr),
    .oob_wr_data(oob_wr_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [DEPTH];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
    return BC && (a >= 32'(DEPTH));
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'(a % 32'(DEPTH));
  endfunction

  function automatic bit get_err();
`ifdef MEM_BOUNDS_CHECK_EN
    return bus.err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_apply(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] exp_rd, output bit exp_err);
    exp_err = oor(a);
    exp_rd  = '0;
    if (!exp_err) begin
      if (wr)      model[idx(a)] = d;
      else if (rd) exp_rd = model[idx(a)];
    end
  endtask

  task automatic oob(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    oob_wen = 1'b1; oob_wr_addr = a; oob_wr_data = d;
    @(negedge clk);
    oob_wen = 1'b0;
    if (!oor(a)) model[idx(a)] = d;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bus.rd_req = rd; bus.wr_req = wr; bus.addr = a; bus.wr_data = d;
  endtask

  // Returns at the negedge of the ack cycle (or after the cycle budget expires).
  task automatic wait_ack(output int lat, output int busy_cnt, output logic [31:0] rdat, output bit e);
    @(negedge clk);
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    lat = 1; busy_cnt = 0;
    while (!bus.ack && lat < 40) begin
      if (bus.busy) busy_cnt++;
      lat++;
      @(negedge clk);
    end
    rdat = bus.rd_data;
    e    = get_err();
  endtask

  task automatic txn_check(input string nm, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd, input bit exp_err);
    int lat, bc;
    logic [31:0] rdat;
    bit e;
    @(negedge clk);
    issue(rd, wr, a, d);
    wait_ack(lat, bc, rdat, e);
    check({nm, " latency"}, lat, LAT);
    check({nm, " busy cycles"}, bc, LAT - 1);
    check({nm, " busy in ack"}, bus.busy, 1'b0);
    check({nm, " rd_data"}, rdat, exp_rd);
`ifdef MEM_BOUNDS_CHECK_EN
    check({nm, " err"}, e, exp_err);
`endif
    @(negedge clk);
    check({nm, " ack drop"}, bus.ack, 1'b0);
    check({nm, " rd_data drop"}, bus.rd_data, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bc, n_ack;
    logic [31:0] rdat, got, exp_rd, old;
    bit e, exp_err;

    vecs[0] = '{1'b1, 1'b0, 32'd3,    32'h0,        32'hDEADBEEF,          1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'd7,    32'h12345678, 32'h0,                 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'd7,    32'h0,        32'h12345678,          1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'd2,    32'hA5,       32'h0,                 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'd2,    32'h0,        32'hA5,                1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'd1025, 32'h0,        BC ? 32'h0 : 32'h99,   BC};
    vecs[6] = '{1'b0, 1'b1, 32'd1026, 32'hCAFE,     32'h0,                 BC};
    vecs[7] = '{1'b1, 1'b0, 32'd2,    32'h0,        BC ? 32'hA5 : 32'hCAFE, 1'b0};

    rst = 1'b1; oob_wen = 1'b0; oob_wr_addr = '0; oob_wr_data = '0;
    issue(1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check("reset ack", bus.ack, 1'b0);
    check("reset busy", bus.busy, 1'b0);
    check("reset rd_data", bus.rd_data, 32'h0);
`ifdef MEM_BOUNDS_CHECK_EN
    check("reset err", bus.err, 1'b0);
`endif
    rst = 1'b0;

    // Preload every word so no read ever returns an unknown value.
    oob_wen = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      oob_wr_addr = i;
      oob_wr_data = i * 32'h9E3779B1;
      model[i]    = i * 32'h9E3779B1;
      @(negedge clk);
    end
    oob_wen = 1'b0;
    oob(32'd3, 32'hDEADBEEF);
    oob(32'd1, 32'h99);

    for (int i = 0; i < 8; i++) begin
      model_apply(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, exp_rd, exp_err);
      txn_check($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d,
                vecs[i].exp_rd, vecs[i].exp_err);
    end

    // Request issued during the ack cycle is accepted.
    @(negedge clk);
    issue(1'b1, 1'b0, 32'd3, '0);
    wait_ack(lat, bc, rdat, e);
    check("b2b first rd_data", rdat, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 32'd7, '0);
    wait_ack(lat, bc, rdat, e);
    check("b2b second latency", lat, LAT);
    check("b2b second rd_data", rdat, 32'h12345678);

    // A write presented while busy is ignored: one ack, no side effect.
    @(negedge clk);
    issue(1'b1, 1'b0, 32'd3, '0);
    @(negedge clk);
    issue(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    issue(1'b0, 1'b1, 32'd3, 32'hBAD);
    @(negedge clk);
    issue(1'b0, 1'b0, '0, '0);
    n_ack = 0; got = '0;
    for (int i = 0; i < 3 * LAT; i++) begin
      if (bus.ack) begin n_ack++; got = bus.rd_data; end
      @(negedge clk);
    end
    check("busy-ignore ack count", n_ack, 1);
    check("busy-ignore rd_data", got, 32'hDEADBEEF);
    txn_check("busy-ignore readback", 1'b1, 1'b0, 32'd3, '0, 32'hDEADBEEF, 1'b0);

    // Reset two cycles into a write discards it.
    oob(32'd4, 32'h11);
    @(negedge clk);
    issue(1'b0, 1'b1, 32'd4, 32'h55);
    @(negedge clk);
    issue(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst-mid busy", bus.busy, 1'b0);
    n_ack = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      if (bus.ack) n_ack++;
      @(negedge clk);
    end
    check("rst-mid ack count", n_ack, 0);
    txn_check("rst-mid readback", 1'b1, 1'b0, 32'd4, '0, 32'h11, 1'b0);

    // OOB write on the same edge a read of that word completes: read sees old data.
    old = model[9];
    @(negedge clk);
    issue(1'b1, 1'b0, 32'd9, '0);
    @(negedge clk);
    issue(1'b0, 1'b0, '0, '0);
    repeat (LAT - 2) @(negedge clk);
    oob_wen = 1'b1; oob_wr_addr = 32'd9; oob_wr_data = 32'h77;
    @(negedge clk);
    oob_wen = 1'b0;
    model[9] = 32'h77;
    check("oob-vs-read ack", bus.ack, 1'b1);
    check("oob-vs-read old data", bus.rd_data, old);
    txn_check("oob-vs-read readback", 1'b1, 1'b0, 32'd9, '0, 32'h77, 1'b0);

    // OOB and core write to the same word on the same edge: core wins.
    @(negedge clk);
    issue(1'b0, 1'b1, 32'd10, 32'hC0DE);
    @(negedge clk);
    issue(1'b0, 1'b0, '0, '0);
    repeat (LAT - 2) @(negedge clk);
    oob_wen = 1'b1; oob_wr_addr = 32'd10; oob_wr_data = 32'h66;
    @(negedge clk);
    oob_wen = 1'b0;
    model[10] = 32'hC0DE;
    check("oob-vs-write ack", bus.ack, 1'b1);
    txn_check("oob-vs-write readback", 1'b1, 1'b0, 32'd10, '0, 32'hC0DE, 1'b0);

    // Randomized traffic with interleaved OOB writes.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, d;
      int op;
      bit rd, wr;
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 31);
        if ($urandom_range(0, 3) == 0) a = a | ($urandom_range(1, 7) << 10);
        oob(a, $urandom);
      end
      a = $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom_range(1, 7) << 10);
      d  = $urandom;
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      model_apply(rd, wr, a, d, exp_rd, exp_err);
      txn_check($sformatf("rand%0d", i), rd, wr, a, d, exp_rd, exp_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
